fetch_queue_unit: RTL and testbench

//  Instruction-fetch front end for the pipelined LoongArch core. Generates the fetch PC and

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_queue_unit_sync_fifo.sv | 57 +++++
 rtl/fetch_queue_unit.sv | 117 +++++++++++
 tb/tb_fetch_queue_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types and constants for the fetch front end and decode.
// Optional build macro: FETCH_PERF_CNT_EN (see fetch_queue_unit.sv).
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Saturating 32-bit add for event counters
    function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Generic synchronous FIFO with synchronous flush; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC generation, single in-flight SRAM read tracking and the fetch queue.
// Define FETCH_PERF_CNT_EN to add perf_fetch_cnt / perf_flush_cnt outputs.
module fetch_queue_unit #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int QDEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            inst_sram_en,
    output logic [XLEN-1:0] inst_sram_addr,
    input  logic [XLEN-1:0] inst_sram_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    import cpu_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_inflight;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_occ;
    logic              w_empty;
    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_head;
    logic [XLEN-1:0]   w_redir_pc;

    // A slot is reserved for the read in flight so a push never hits a full queue
    assign w_occ      = w_count + CW'(r_inflight);
    assign w_req      = !reset && !redirect_valid && (w_occ < CW'(QDEPTH));
    assign w_push     = r_inflight && !redirect_valid && !reset;
    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    assign inst_sram_en   = w_req;
    assign inst_sram_addr = r_fetch_pc;

    assign out_valid = !w_empty && !redirect_valid && !reset;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = w_head[2*XLEN-1:XLEN];
    assign out_inst  = w_head[XLEN-1:0];

    // PC generation and in-flight tracking; redirect kills the returning read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_req_pc   <= r_fetch_pc;
            end
        end
    end

    sync_fifo #(
        .DEPTH(QDEPTH),
        .WIDTH(2 * XLEN)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_data({r_req_pc, inst_sram_rdata}),
        .i_pop      (w_pop),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head_data(w_head)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [31:0] w_discard;

    // Entries lost to a redirect: queued ones plus the read it kills
    assign w_discard = 32'(w_count) + 32'(r_inflight);

    // Saturating event counters for pops and redirect discards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch <= sat_add32(r_perf_fetch, 32'd1);
            end
            if (redirect_valid) begin
                r_perf_flush <= sat_add32(r_perf_flush, w_discard);
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: vector table plus hand-written sequences.
// SRAM model returns ~addr one cycle after each enabled read.
module tb_fetch_queue_unit;

    localparam logic [31:0] RC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        een;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic rst, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        reset = rst;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic sv(input int i, input logic rst, input logic rv,
                      input logic [31:0] rpc, input logic rdy,
                      input logic een, input logic [31:0] eaddr,
                      input logic evld, input logic [31:0] epc);
        vt[i] = '{rst, rv, rpc, rdy, een, eaddr, evld, epc};
    endtask

    task automatic chk_out(input string tag, input logic een,
                           input logic [31:0] eaddr, input logic evld,
                           input logic [31:0] epc);
        chk({tag, ".en"}, 32'(inst_sram_en), 32'(een));
        if (een) chk({tag, ".addr"}, inst_sram_addr, eaddr);
        chk({tag, ".valid"}, 32'(out_valid), 32'(evld));
        if (evld) begin
            chk({tag, ".pc"}, out_pc, epc);
            chk({tag, ".inst"}, out_inst, ~epc);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch0;
    logic [31:0] flush0;
`endif

    initial begin
        inst_sram_rdata = '0;
        sv( 0, 1, 0, 0,            1, 0, 0,         0, 0);
        sv( 1, 0, 0, 0,            1, 1, RC,        0, 0);
        sv( 2, 0, 0, 0,            1, 1, RC+4,      0, 0);
        sv( 3, 0, 0, 0,            1, 1, RC+8,      1, RC);
        sv( 4, 0, 0, 0,            1, 1, RC+12,     1, RC+4);
        sv( 5, 0, 0, 0,            0, 1, RC+16,     1, RC+8);
        sv( 6, 0, 0, 0,            0, 1, RC+20,     1, RC+8);
        sv( 7, 0, 0, 0,            0, 0, 0,         1, RC+8);
        sv( 8, 0, 0, 0,            0, 0, 0,         1, RC+8);
        sv( 9, 0, 0, 0,            1, 0, 0,         1, RC+8);
        sv(10, 0, 0, 0,            1, 1, RC+24,     1, RC+12);
        sv(11, 0, 0, 0,            1, 1, RC+28,     1, RC+16);
        sv(12, 0, 1, 32'h1c000103, 1, 0, 0,         0, 0);
        sv(13, 0, 0, 0,            1, 1, RC+32'h100, 0, 0);
        sv(14, 0, 0, 0,            1, 1, RC+32'h104, 0, 0);
        sv(15, 0, 0, 0,            1, 1, RC+32'h108, 1, RC+32'h100);
        sv(16, 1, 1, 32'h0000_0040, 0, 0, 0,        0, 0);
        sv(17, 0, 0, 0,            1, 1, RC,        0, 0);
        sv(18, 0, 0, 0,            1, 1, RC+4,      0, 0);
        sv(19, 0, 0, 0,            1, 1, RC+8,      1, RC);

        drive(1, 0, 0, 0);
        nxt();
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy);
            chk_out($sformatf("v%0d", i), vt[i].een, vt[i].eaddr,
                    vt[i].evld, vt[i].epc);
            nxt();
        end

        // Full queue, then redirect while the head is being offered
        drive(1, 0, 0, 0);
        nxt();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0);
            chk($sformatf("fill%0d.en", k), 32'(inst_sram_en),
                32'(k < 4));
            nxt();
        end
        drive(0, 0, 0, 0);
        chk("full.pc", out_pc, RC);
`ifdef FETCH_PERF_CNT_EN
        fetch0 = perf_fetch_cnt;
        flush0 = perf_flush_cnt;
        chk("perf.rst_fetch", fetch0, 32'd0);
`endif
        drive(0, 1, 32'hffff_fffe, 1);
        chk_out("redir", 0, 0, 0, 0);
        nxt();
`ifdef FETCH_PERF_CNT_EN
        chk("perf.flush", perf_flush_cnt - flush0, 32'd4);
        chk("perf.nopop", perf_fetch_cnt - fetch0, 32'd0);
`endif
        drive(0, 0, 0, 1);
        chk_out("wrap0", 1, 32'hffff_fffc, 0, 0);
        nxt();
        drive(0, 0, 0, 1);
        chk_out("wrap1", 1, 32'h0, 0, 0);
        nxt();
        drive(0, 0, 0, 1);
        chk_out("wrap2", 1, 32'h4, 1, 32'hffff_fffc);
        nxt();
        drive(0, 0, 0, 0);
        chk_out("wrap3", 1, 32'h8, 1, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf.pop", perf_fetch_cnt - fetch0, 32'd1);
`endif
        nxt();

        // Reset with a full queue and a redirect at the same time
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0);
            nxt();
        end
        drive(0, 0, 0, 0);
        chk("prerst.valid", 32'(out_valid), 32'd1);
        chk("prerst.en", 32'(inst_sram_en), 32'd0);
        drive(1, 1, 32'h0000_2000, 1);
        chk_out("rstredir", 0, 0, 0, 0);
        nxt();
        drive(0, 0, 0, 1);
        chk_out("postrst", 1, RC, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf.rst_flush", perf_flush_cnt, 32'd0);
`endif

        // Unthrottled stream from reset release
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 1);
            chk_out($sformatf("str%0d", k), 1, RC + 32'(4 * k),
                    k >= 2, RC + 32'(4 * (k - 2)));
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
